// File: rtl/soduku_controller.sv
// Sequencing controller for the singleton-propagation sudoku solver core.
// Validates a BCD puzzle, loads it into the solver and reports the first outcome.
module soduku_controller #(
  parameter int MAX_ITER = 200
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         start_in,
  input  logic [323:0] board_in,
  output logic         ready_out,
  output logic         solver_reset_out,
  output logic [323:0] solver_board_out,
  input  logic [323:0] solver_board_in,
  output logic         done_out,
  output logic [1:0]   status_out,
  output logic [323:0] result_out,
  output logic [7:0]   iter_out
);

  localparam int         CELLS      = 81;
  localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_SOLVED  = 2'b00,
    ST_STUCK   = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_INVALID = 2'b11
  } status_t;

  state_t         state_q, state_d;
  status_t        status_q, status_d;
  logic [323:0]   solver_board_q, solver_board_d;
  logic [323:0]   prev_q, prev_d;
  logic [323:0]   result_q, result_d;
  logic [7:0]     iter_q, iter_d;
  logic [7:0]     iter_out_q, iter_out_d;

  logic           board_in_bad;
  logic           solver_full;
  logic           run_exit;

  // Digit scans: any non-BCD nibble in the request, any empty cell in the solver board.
  always_comb begin
    board_in_bad = 1'b0;
    solver_full  = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (board_in[4*i +: 4] > 4'd9) begin
        board_in_bad = 1'b1;
      end
      if (solver_board_in[4*i +: 4] == 4'd0) begin
        solver_full = 1'b0;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    solver_board_d = solver_board_q;
    prev_d         = prev_q;
    result_d       = result_q;
    iter_d         = iter_q;
    iter_out_d     = iter_out_q;
    run_exit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          solver_board_d = board_in;
          if (board_in_bad) begin
            state_d    = DONE;
            status_d   = ST_INVALID;
            result_d   = board_in;
            iter_out_d = 8'd0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        prev_d  = solver_board_in;
        iter_d  = 8'd0;
        state_d = RUN;
      end
      RUN: begin
        // Priority: solved beats stuck beats timeout.
        if (solver_full) begin
          run_exit = 1'b1;
          status_d = ST_SOLVED;
        end else if (solver_board_in == prev_q) begin
          run_exit = 1'b1;
          status_d = ST_STUCK;
        end else if (iter_q == ITER_LIMIT) begin
          run_exit = 1'b1;
          status_d = ST_TIMEOUT;
        end else begin
          prev_d = solver_board_in;
          iter_d = iter_q + 8'd1;
        end
        if (run_exit) begin
          state_d    = DONE;
          result_d   = solver_board_in;
          iter_out_d = iter_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= IDLE;
      status_q       <= ST_SOLVED;
      solver_board_q <= '0;
      prev_q         <= '0;
      result_q       <= '0;
      iter_q         <= 8'd0;
      iter_out_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      solver_board_q <= solver_board_d;
      prev_q         <= prev_d;
      result_q       <= result_d;
      iter_q         <= iter_d;
      iter_out_q     <= iter_out_d;
    end
  end

  assign ready_out        = (state_q == IDLE);
  assign solver_reset_out = (state_q == LOAD);
  assign done_out         = (state_q == DONE);
  assign solver_board_out = solver_board_q;
  assign status_out       = status_q;
  assign result_out       = result_q;
  assign iter_out         = iter_out_q;

endmodule

// File: tb/tb_soduku_controller.sv
// Self-checking bench for soduku_controller: behavioural singleton solver plus a
// high-level run model; table-driven, randomized and hand-written sequences.
module tb_soduku_controller;

  localparam int BW = 324;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [BW-1:0] board;

  logic          ready_a, sr_a, done_a;
  logic [1:0]    status_a;
  logic [BW-1:0] sbo_a, result_a;
  logic [7:0]    iter_a;
  logic          ready_b, sr_b, done_b;
  logic [1:0]    status_b;
  logic [BW-1:0] sbo_b, result_b;
  logic [7:0]    iter_b;

  logic [BW-1:0] sboard_a, sboard_b;
  logic          sres_a, sres_b;

  int            sel;
  int            checks;
  int            failures;

  typedef struct {
    int            sel;
    logic [BW-1:0] puz;
    logic [1:0]    st;
    logic [BW-1:0] res;
    int            it;
    int            lat;
    int            pulses;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  soduku_controller dut_a (
    .clk_in(clk), .reset_in(reset), .start_in(start_a), .board_in(board),
    .ready_out(ready_a), .solver_reset_out(sr_a), .solver_board_out(sbo_a),
    .solver_board_in(sboard_a), .done_out(done_a), .status_out(status_a),
    .result_out(result_a), .iter_out(iter_a)
  );

  soduku_controller #(.MAX_ITER(1)) dut_b (
    .clk_in(clk), .reset_in(reset), .start_in(start_b), .board_in(board),
    .ready_out(ready_b), .solver_reset_out(sr_b), .solver_board_out(sbo_b),
    .solver_board_in(sboard_b), .done_out(done_b), .status_out(status_b),
    .result_out(result_b), .iter_out(iter_b)
  );

  // One propagation step: every empty cell with exactly one candidate is filled.
  function automatic logic [BW-1:0] sol_step(input logic [BW-1:0] b);
    int            g[81];
    logic [BW-1:0] nb;
    logic [15:0]   used;
    int            r, c, br, bc, cnt, val;
    nb = b;
    for (int i = 0; i < 81; i++) g[i] = int'(b[BW-1-4*i -: 4]);
    for (int i = 0; i < 81; i++) begin
      if (g[i] == 0) begin
        r = i / 9; c = i % 9; br = (r / 3) * 3; bc = (c / 3) * 3;
        used = '0;
        for (int k = 0; k < 9; k++) begin
          used[g[r*9 + k]] = 1'b1;
          used[g[k*9 + c]] = 1'b1;
          used[g[(br + k/3)*9 + bc + k%3]] = 1'b1;
        end
        cnt = 0; val = 0;
        for (int d = 1; d <= 9; d++) begin
          if (!used[d]) begin
            cnt++;
            val = d;
          end
        end
        if (cnt == 1) nb[BW-1-4*i -: 4] = 4'(val);
      end
    end
    return nb;
  endfunction

  assign sres_a = reset | sr_a;
  assign sres_b = reset | sr_b;

  always_ff @(posedge clk or posedge sres_a) begin
    if (sres_a) sboard_a <= sbo_a;
    else        sboard_a <= sol_step(sboard_a);
  end

  always_ff @(posedge clk or posedge sres_b) begin
    if (sres_b) sboard_b <= sbo_b;
    else        sboard_b <= sol_step(sboard_b);
  end

  logic          ready_s, sr_s, done_s;
  logic [1:0]    status_s;
  logic [BW-1:0] result_s, sbo_s;
  logic [7:0]    iter_s;
  assign ready_s  = (sel == 0) ? ready_a  : ready_b;
  assign sr_s     = (sel == 0) ? sr_a     : sr_b;
  assign done_s   = (sel == 0) ? done_a   : done_b;
  assign status_s = (sel == 0) ? status_a : status_b;
  assign result_s = (sel == 0) ? result_a : result_b;
  assign sbo_s    = (sel == 0) ? sbo_a    : sbo_b;
  assign iter_s   = (sel == 0) ? iter_a   : iter_b;

  function automatic bit has_bad(input logic [BW-1:0] b);
    for (int i = 0; i < 81; i++) if (b[BW-1-4*i -: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_full(input logic [BW-1:0] b);
    for (int i = 0; i < 81; i++) if (b[BW-1-4*i -: 4] == 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Whole-run outcome: board sequence b0, step(b0), ... judged solved/stuck/limit.
  task automatic model_run(input logic [BW-1:0] puz, input int max_iter,
                           output logic [1:0] st, output logic [BW-1:0] res,
                           output int it, output int lat);
    logic [BW-1:0] prev, cur;
    int            n;
    st = 2'b11; res = puz; it = 0; lat = 1;
    if (!has_bad(puz)) begin
      prev = puz; cur = puz; n = 0; lat = 3;
      for (int guard = 0; guard < 300; guard++) begin
        cur = sol_step(cur);
        lat++;
        if (is_full(cur)) begin st = 2'b00; res = cur; it = n; break; end
        if (cur == prev)  begin st = 2'b01; res = cur; it = n; break; end
        if (n == max_iter) begin st = 2'b10; res = cur; it = n; break; end
        prev = cur;
        n++;
      end
    end
  endtask

  function automatic logic [BW-1:0] make_grid(input bit shuffle);
    int            perm[9];
    int            j, tmp;
    logic [BW-1:0] b;
    for (int k = 0; k < 9; k++) perm[k] = k + 1;
    if (shuffle) begin
      for (int k = 8; k > 0; k--) begin
        j = int'($urandom_range(k, 0));
        tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
    end
    for (int i = 0; i < 81; i++)
      b[BW-1-4*i -: 4] = 4'(perm[((i/9)*3 + (i/9)/3 + i%9) % 9]);
    return b;
  endfunction

  function automatic logic [BW-1:0] blank_cells(input logic [BW-1:0] b, input int n);
    int cnt, idx;
    cnt = 0;
    while (cnt < n) begin
      idx = int'($urandom_range(80, 0));
      if (b[BW-1-4*idx -: 4] != 4'd0) begin
        b[BW-1-4*idx -: 4] = 4'd0;
        cnt++;
      end
    end
    return b;
  endfunction

  function automatic logic [BW-1:0] from_string(input string s);
    logic [BW-1:0] b;
    for (int i = 0; i < 81; i++) b[BW-1-4*i -: 4] = 4'(s[i] - 8'd48);
    return b;
  endfunction

  task automatic add_vec(input int s, input logic [BW-1:0] puz);
    vec_t v;
    v.sel = s;
    v.puz = puz;
    model_run(puz, (s == 0) ? 200 : 1, v.st, v.res, v.it, v.lat);
    v.pulses = (v.st == 2'b11) ? 0 : 1;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [BW-1:0] act,
                              input logic [BW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: done_out never seen within cycle budget", name);
  endtask

  // Called at a negedge while the selected DUT is idle; returns in the DONE cycle.
  task automatic apply_stimulus(input int s, input logic [BW-1:0] puz,
                                output int lat, output int pulses, output bit timed_out);
    sel = s;
    board = puz;
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0; pulses = 0; timed_out = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (sr_s) pulses++;
      if (done_s) begin
        lat = cyc;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, output bit timed_out);
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done_s) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (timed_out) report_timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            lat, pulses, it;
    bit            to;
    logic [1:0]    st;
    logic [BW-1:0] full_grid, bad_grid, sol30, esc, wiki, tmo_puz, puz, res;
    vec_t          v;

    checks = 0; failures = 0;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; board = '0; sel = 0;

    full_grid = make_grid(1'b0);
    bad_grid  = full_grid;
    bad_grid[BW-1-4*40 -: 4] = 4'hA;
    sol30 = blank_cells(full_grid, 30);
    esc   = from_string("100007090030020008009600500005300900010080002600004000300000010040000007007000300");
    wiki  = from_string("530070000600195000098000060800060003400803001700020006060000280000419005000080079");

    tmo_puz = blank_cells(make_grid(1'b1), 50);
    for (int t = 0; t < 200; t++) begin
      puz = blank_cells(make_grid(1'b1), int'($urandom_range(64, 40)));
      model_run(puz, 1, st, res, it, lat);
      tmo_puz = puz;
      if (st == 2'b10) break;
    end

    v.sel = 0; v.puz = full_grid; v.st = 2'b00; v.res = full_grid; v.it = 0; v.lat = 4; v.pulses = 1;
    vecs.push_back(v);
    v.sel = 0; v.puz = bad_grid;  v.st = 2'b11; v.res = bad_grid;  v.it = 0; v.lat = 1; v.pulses = 0;
    vecs.push_back(v);
    v.sel = 1; v.puz = full_grid; v.st = 2'b00; v.res = full_grid; v.it = 0; v.lat = 4; v.pulses = 1;
    vecs.push_back(v);
    add_vec(0, sol30);
    add_vec(0, esc);
    add_vec(0, wiki);
    add_vec(1, tmo_puz);
    add_vec(1, wiki);
    for (int r = 0; r < 8; r++) begin
      puz = blank_cells(make_grid(1'b1), int'($urandom_range(60, 10)));
      if ($urandom_range(3, 0) == 0)
        puz[BW-1-4*int'($urandom_range(80, 0)) -: 4] = 4'(int'($urandom_range(15, 10)));
      add_vec(int'($urandom_range(1, 0)), puz);
    end

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("idle a", BW'({ready_a, done_a, status_a, iter_a, sr_a, |result_a, |sbo_a}),
                   BW'({1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0}));
      check_output("idle b", BW'({ready_b, done_b, status_b, iter_b, sr_b, |result_b, |sbo_b}),
                   BW'({1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0}));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].sel, vecs[i].puz, lat, pulses, to);
      if (to) begin
        report_timeout($sformatf("v%0d", i));
      end else begin
        check_output($sformatf("v%0d latency", i), BW'(lat), BW'(vecs[i].lat));
        check_output($sformatf("v%0d status", i), BW'(status_s), BW'(vecs[i].st));
        check_output($sformatf("v%0d result", i), result_s, vecs[i].res);
        check_output($sformatf("v%0d iter", i), BW'(iter_s), BW'(vecs[i].it));
        check_output($sformatf("v%0d solver_reset pulses", i), BW'(pulses), BW'(vecs[i].pulses));
        check_output($sformatf("v%0d solver_board_out", i), sbo_s, vecs[i].puz);
      end
      @(negedge clk);
      check_output($sformatf("v%0d ready after done", i), BW'({ready_s, done_s}), BW'(2'b10));
    end

    // Start pulsed while RUN is active must neither disturb nor queue a run.
    model_run(sol30, 200, st, res, it, lat);
    sel = 0; board = sol30; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done("ignored start", to);
    if (!to) begin
      check_output("ignored start status", BW'(status_a), BW'(st));
      check_output("ignored start result", result_a, res);
      check_output("ignored start iter", BW'(iter_a), BW'(it));
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check_output("no queued run / hold", BW'({ready_a, sr_a, done_a, status_a, iter_a}),
                     BW'({1'b1, 1'b0, 1'b0, st, 8'(it)}));
      end
    end

    // Reset in the middle of a run after an invalid run left status 11.
    apply_stimulus(0, bad_grid, lat, pulses, to);
    @(negedge clk);
    board = sol30; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("in RUN before reset", BW'({ready_a, sr_a, done_a}), BW'(3'b000));
    reset = 1'b1;
    #1;
    check_output("mid-run reset ctrl", BW'({ready_a, done_a, status_a, iter_a, sr_a}),
                 BW'({1'b1, 1'b0, 2'b00, 8'd0, 1'b0}));
    check_output("mid-run reset result", result_a, '0);
    check_output("mid-run reset solver_board_out", sbo_a, '0);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_output("after reset idle", BW'({ready_a, done_a, sr_a}), BW'(3'b100));
    end
    apply_stimulus(0, full_grid, lat, pulses, to);
    if (to) report_timeout("restart after reset");
    else begin
      check_output("restart latency", BW'(lat), BW'(4));
      check_output("restart status", BW'(status_a), BW'(2'b00));
      check_output("restart result", result_a, full_grid);
    end
    @(negedge clk);

    // start_in held high: back-to-back runs with a single IDLE cycle between.
    sel = 0; board = full_grid; start_a = 1'b1;
    @(negedge clk);
    wait_done("back-to-back first", to);
    if (!to) begin
      @(negedge clk);
      check_output("b2b gap idle", BW'({ready_a, sr_a}), BW'(2'b10));
      @(negedge clk);
      check_output("b2b second load", BW'({ready_a, sr_a}), BW'(2'b01));
      start_a = 1'b0;
      wait_done("back-to-back second", to);
      if (!to) check_output("b2b second status", BW'(status_a), BW'(2'b00));
    end
    start_a = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
